// File: rtl/inst_fetch_resp.sv
// ----------------------------------------------------------------------------
// inst_fetch_resp
//   Instruction-memory responder for the fetch stage. Each cycle it samples the
//   PC presented by fetch and hands the addressed 32-bit word, registered, to
//   the ID stage. It honours the stall vector, squashes wrong-path work on a
//   flush, and flags misaligned or out-of-range PCs. A load port fills the
//   instruction store, and the store is never cleared by reset.
//
// Ports
//   clock        in   1           clock, all updates on posedge
//   reset        in   1           synchronous, active-high
//   stall        in   6           [0]=IF stalled, [1]=ID stalled, [5:2] ignored
//   flush        in   1           squash the instruction entering ID
//   pc_in        in   32          PC presented by fetch
//   load_enable  in   1           write load_data into the store
//   load_addr    in   ADDR_WIDTH  word address for the load
//   load_data    in   32          word to write
//   id_pc        out  32          PC of the instruction held for ID
//   id_inst      out  32          instruction held for ID
//   id_valid     out  1           1 = real fetch (faulted ones too), 0 = bubble
//   id_fault     out  2           [0]=misaligned PC, [1]=PC beyond store
//   fetch_count  out  32          good instructions delivered to ID (wraps)
// ----------------------------------------------------------------------------
module inst_fetch_resp #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [5:0]            stall,
    input  logic                  flush,
    input  logic [31:0]           pc_in,
    input  logic                  load_enable,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic [31:0]           id_pc,
    output logic [31:0]           id_inst,
    output logic                  id_valid,
    output logic [1:0]            id_fault,
    output logic [31:0]           fetch_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] r_store [DEPTH];

    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic [1:0]  r_id_fault;
    logic [31:0] r_fetch_count;

    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [31:0]           w_word;
    logic                  w_misaligned;
    logic                  w_beyond;
    logic                  w_unused_stall;

    // Only the two low stall bits concern this stage.
    assign w_unused_stall = ^stall[5:2];

    assign w_word_addr  = pc_in[ADDR_WIDTH+1:2];
    assign w_word       = r_store[w_word_addr];
    assign w_misaligned = (pc_in[1:0] != 2'b00);
    assign w_beyond     = (pc_in[31:ADDR_WIDTH+2] != '0);

    // The store is written with a non-blocking update, so a fetch of the word
    // being loaded on the same edge sees the old contents. Reset does not touch it.
    always_ff @(posedge clock) begin
        if (load_enable) begin
            r_store[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_id_pc       <= 32'h0;
            r_id_inst     <= NOP_INST;
            r_id_valid    <= 1'b0;
            r_id_fault    <= 2'b00;
            r_fetch_count <= 32'h0;
        end else if (flush) begin
            // Flush wins over any stall: the slot becomes a bubble.
            r_id_pc    <= pc_in;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
            r_id_fault <= 2'b00;
        end else if (stall[1]) begin
            // ID stalled: hold everything.
            r_id_pc       <= r_id_pc;
            r_id_inst     <= r_id_inst;
            r_id_valid    <= r_id_valid;
            r_id_fault    <= r_id_fault;
            r_fetch_count <= r_fetch_count;
        end else if (stall[0]) begin
            r_id_pc    <= pc_in;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
            r_id_fault <= 2'b00;
        end else begin
            r_id_pc    <= pc_in;
            r_id_valid <= 1'b1;
            r_id_fault <= {w_beyond, w_misaligned};
            // A faulted fetch is still valid so the fault travels down the pipe,
            // but it carries a NOP and is not counted as a good instruction.
            if (w_misaligned || w_beyond) begin
                r_id_inst <= NOP_INST;
            end else begin
                r_id_inst     <= w_word;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign id_pc       = r_id_pc;
    assign id_inst     = r_id_inst;
    assign id_valid    = r_id_valid;
    assign id_fault    = r_id_fault;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_inst_fetch_resp.sv
module tb_inst_fetch_resp;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   pc_in;
    logic          load_enable;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [31:0]   id_pc;
    logic [31:0]   id_inst;
    logic          id_valid;
    logic [1:0]    id_fault;
    logic [31:0]   fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_valid;
    logic [1:0]  m_fault;
    logic [31:0] m_count;

    inst_fetch_resp #(.ADDR_WIDTH(AW), .NOP_INST(32'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .pc_in       (pc_in),
        .load_enable (load_enable),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .id_fault    (id_fault),
        .fetch_count (fetch_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    id_pc,              m_pc);
        check({tag, ".inst"},  id_inst,            m_inst);
        check({tag, ".valid"}, 32'(id_valid),      32'(m_valid));
        check({tag, ".fault"}, 32'(id_fault),      32'(m_fault));
        check({tag, ".count"}, fetch_count,        m_count);
    endtask

    // Model: applies the priority rules to the inputs present at the edge,
    // then performs the load (so same-cycle fetches see the old word).
    task automatic model_edge();
        logic mis, beyond;
        if (reset) begin
            m_pc = 0; m_inst = 0; m_valid = 0; m_fault = 0; m_count = 0;
        end else if (flush) begin
            m_pc = pc_in; m_inst = 0; m_valid = 0; m_fault = 0;
        end else if (stall[1]) begin
            // hold
        end else if (stall[0]) begin
            m_pc = pc_in; m_inst = 0; m_valid = 0; m_fault = 0;
        end else begin
            mis    = (pc_in % 4) != 0;
            beyond = pc_in >= 32'(DEPTH * 4);
            m_pc    = pc_in;
            m_valid = 1;
            m_fault = {beyond, mis};
            if (mis || beyond) m_inst = 0;
            else begin
                m_inst  = m_mem[pc_in / 4];
                m_count = m_count + 1;
            end
        end
        if (load_enable) m_mem[load_addr] = load_data;
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; flush = 0; load_enable = 0; load_addr = 0; load_data = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        pc_in = 0;
        m_pc = 0; m_inst = 0; m_valid = 0; m_fault = 0; m_count = 0;

        // Fill the whole store during reset; words 0..3 get 11,22,33,44.
        for (int i = 0; i < DEPTH; i++) begin
            load_enable = 1;
            load_addr   = AW'(i);
            load_data   = (i < 4) ? 32'((i + 1) * 32'h11) : $urandom;
            step("reset_load");
        end
        load_enable = 0;
        step("reset_state");

        // 1: sequential fetch
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'(i * 4);
            step("t1_fetch");
        end
        check("t1_inst_last", id_inst, 32'h44);
        check("t1_count4", fetch_count, 32'd4);

        // 2: ID stall holds, IF stall inserts bubble
        stall = 6'b000011;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'(16 + i * 4);
            step("t2_hold");
        end
        stall = 6'b000001;
        pc_in = 32'h20;
        step("t2_bubble");
        check("t2_bubble_pc", id_pc, 32'h20);
        stall = 0;

        // 3: faults
        pc_in = 32'h6;    step("t3_mis");
        check("t3_mis_fault", 32'(id_fault), 32'd1);
        pc_in = 32'h1000; step("t3_beyond");
        check("t3_beyond_fault", 32'(id_fault), 32'd2);
        pc_in = 32'h1002; step("t3_both");
        check("t3_both_fault", 32'(id_fault), 32'd3);

        // 4: flush beats stall
        pc_in = 32'h4; step("t4_pre");
        flush = 1; stall = 6'b000011; pc_in = 32'h8;
        step("t4_flush");
        check("t4_flush_valid", 32'(id_valid), 32'd0);
        flush = 0; stall = 0;

        // 5: read-before-write
        pc_in = 32'h8; load_enable = 1; load_addr = 2; load_data = 32'h99;
        step("t5_old");
        check("t5_old_word", id_inst, 32'h33);
        load_enable = 0;
        step("t5_new");
        check("t5_new_word", id_inst, 32'h99);

        // 6: counter wrap after a forced preset, then reset mid-stall
        @(negedge clock);
        force dut.r_fetch_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_fetch_count;
        m_count = 32'hFFFF_FFFE;
        pc_in = 32'h0; step("t6_wrap1");
        pc_in = 32'h4; step("t6_wrap2");
        check("t6_wrap_zero", fetch_count, 32'h0);
        stall = 6'b000011; flush = 1; reset = 1;
        step("t6_reset");
        reset = 0; flush = 0; stall = 0; pc_in = 32'h8;
        step("t6_store_kept");
        check("t6_store_word", id_inst, 32'h99);

        // Randomized run
        for (int c = 0; c < 600; c++) begin
            int r;
            r = int'($urandom_range(0, 9));
            stall = 6'($urandom_range(0, 63)) & 6'b111100;
            if (r == 0 || r == 1) stall[1] = 1'b1;
            if (r == 0 || r == 2) stall[0] = 1'b1;
            flush       = ($urandom_range(0, 11) == 0);
            reset       = ($urandom_range(0, 49) == 0);
            load_enable = ($urandom_range(0, 2) == 0);
            load_addr   = AW'($urandom_range(0, DEPTH - 1));
            load_data   = $urandom;
            case ($urandom_range(0, 9))
                6:       pc_in = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
                7:       pc_in = {$urandom_range(1, 32'h000F_FFFF), 12'h000} + 32'($urandom_range(0, 1023) * 4);
                8:       pc_in = 32'h8000_0001;
                9:       pc_in = 32'(load_addr) * 4;
                default: pc_in = 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule
